// File: rtl/freq_pulse_gen.sv
// freq_pulse_gen: programmable pulse generator with a double-buffered divisor.
// The effective divisor is D = {PREFIX, nibble}. Each period lasts D cycles:
// psi is high for D>>1 cycles, then low for the remaining cycles.
// Optional feature macro: FDIV_PERIOD_CNT_EN adds the period_cnt port.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   en           run enable; a running period always completes
//   div_in       new divisor low nibble
//   div_load     strobe capturing div_in into the pending register
//   psi          generated pulse (registered, one cycle behind the FSM state)
//   period_done  high during the last cycle of each period
//   div_pend     a captured divisor waits for the next period start
//   div_active   divisor of the current period
//   period_cnt   completed-period count (FDIV_PERIOD_CNT_EN only)
module freq_pulse_gen #(
    parameter logic [3:0] PREFIX = 4'b1011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] div_in,
    input  logic       div_load,
    output logic       psi,
    output logic       period_done,
    output logic       div_pend,
`ifdef FDIV_PERIOD_CNT_EN
    output logic [15:0] period_cnt,
`endif
    output logic [7:0] div_active
);

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   pending_q, pending_d;
    logic            pend_d;
    logic [DW-1:0]   active_d;
    logic            done_d;
    logic            start;
    logic [DW-1:0]   half;
    logic [DW-1:0]   last;

    assign half = div_active >> 1;
    assign last = div_active - DW'(1);

    // Next-state, counter and divisor buffering.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        pending_d = pending_q;
        pend_d    = div_pend;
        active_d  = div_active;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = HIGH;
                    start   = 1'b1;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == half - DW'(1)) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == last) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = HIGH;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load coinciding with a period start bypasses the pending register.
        if (start) begin
            if (div_load) begin
                active_d = {PREFIX, div_in};
                pend_d   = 1'b0;
            end else if (div_pend) begin
                active_d = {PREFIX, pending_q};
                pend_d   = 1'b0;
            end
        end else if (div_load) begin
            pending_d = div_in;
            pend_d    = 1'b1;
        end

        // Registered so that period_done lines up with cnt = D-1.
        done_d = (state_d == LOW) && (cnt_d == active_d - DW'(1));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= '0;
            div_pend    <= 1'b0;
            div_active  <= {PREFIX, 4'h0};
            psi         <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            div_pend    <= pend_d;
            div_active  <= active_d;
            psi         <= (state_q == HIGH);
            period_done <= done_d;
        end
    end

`ifdef FDIV_PERIOD_CNT_EN
    // Completed-period counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (period_done) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule
